decode_execute_reg: RTL and testbench

- Decode→Execute pipeline register. Sits directly downstream of the register file read ports and feeds the execute stage.
- Captures the decoded operands, register addresses, immediate and control bundle.
- Bypasses a same-cycle writeback onto read data. The register file writes on the clock edge but reads combinationally, so a same-cycle writeback would otherwise be read stale.
- Detects load-use hazards and inserts a bubble. Supports stall and flush from the hazard/control logic.

---
 rtl/decode_execute_reg.sv | 115 +++++++++++
 tb/tb_decode_execute_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with writeback bypass, load-use bubble, stall and flush.
// Optional bubble counter output is enabled by defining DEX_PERF_CNT_EN.
module decode_execute_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_d,
    input  logic [3:0]        ra1_d,
    input  logic [3:0]        ra2_d,
    input  logic [3:0]        wa3_d,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [DATA_W-1:0] imm_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              we3_w,
    input  logic [3:0]        wa3_w,
    input  logic [DATA_W-1:0] wd3_w,
    input  logic              stall_e,
    input  logic              flush_e,
    output logic              valid_e,
    output logic [3:0]        ra1_e,
    output logic [3:0]        ra2_e,
    output logic [3:0]        wa3_e,
    output logic [DATA_W-1:0] rd1_e,
    output logic [DATA_W-1:0] rd2_e,
    output logic [DATA_W-1:0] imm_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              hazard_o
`ifdef DEX_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_cnt_o
`endif
);

    logic              r_valid;
    logic [3:0]        r_ra1;
    logic [3:0]        r_ra2;
    logic [3:0]        r_wa3;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [CTRL_W-1:0] r_ctrl;

    logic              w_hazard;
    logic [DATA_W-1:0] w_rd1_byp;
    logic [DATA_W-1:0] w_rd2_byp;
    logic [DATA_W-1:0] w_rd1_ref;
    logic [DATA_W-1:0] w_rd2_ref;

    // A load in execute whose destination feeds decode cannot be forwarded in time.
    assign w_hazard = r_valid && r_ctrl[1] && r_ctrl[0] && valid_d &&
                      (r_wa3 != 4'hF) &&
                      ((ra1_d == r_wa3) || (ra2_d == r_wa3));

    // Register file reads combinationally but writes on the edge, so forward the writeback.
    assign w_rd1_byp = (we3_w && (wa3_w == ra1_d) && (ra1_d != 4'hF)) ? wd3_w : rd1_d;
    assign w_rd2_byp = (we3_w && (wa3_w == ra2_d) && (ra2_d != 4'hF)) ? wd3_w : rd2_d;

    // While held, operands captured earlier may be overwritten by a later writeback.
    assign w_rd1_ref = (r_valid && we3_w && (wa3_w == r_ra1) && (r_ra1 != 4'hF)) ? wd3_w : r_rd1;
    assign w_rd2_ref = (r_valid && we3_w && (wa3_w == r_ra2) && (r_ra2 != 4'hF)) ? wd3_w : r_rd2;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_e || (!stall_e && w_hazard)) begin
            r_valid <= 1'b0;
            r_ra1   <= '0;
            r_ra2   <= '0;
            r_wa3   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
        end else if (stall_e) begin
            r_rd1 <= w_rd1_ref;
            r_rd2 <= w_rd2_ref;
        end else begin
            r_valid <= valid_d;
            r_ra1   <= ra1_d;
            r_ra2   <= ra2_d;
            r_wa3   <= wa3_d;
            r_rd1   <= w_rd1_byp;
            r_rd2   <= w_rd2_byp;
            r_imm   <= imm_d;
            r_ctrl  <= valid_d ? ctrl_d : '0;
        end
    end

    assign valid_e  = r_valid;
    assign ra1_e    = r_ra1;
    assign ra2_e    = r_ra2;
    assign wa3_e    = r_wa3;
    assign rd1_e    = r_rd1;
    assign rd2_e    = r_rd2;
    assign imm_e    = r_imm;
    assign ctrl_e   = r_ctrl;
    assign hazard_o = w_hazard;

`ifdef DEX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;

    // Only hazard bubbles are counted; flush and stall take precedence over the hazard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (!flush_e && !stall_e && w_hazard && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed testbench for decode_execute_reg; counter checks run when DEX_PERF_CNT_EN is defined.
module tb_decode_execute_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_d;
    logic [3:0]  ra1_d, ra2_d, wa3_d;
    logic [31:0] rd1_d, rd2_d, imm_d;
    logic [7:0]  ctrl_d;
    logic        we3_w;
    logic [3:0]  wa3_w;
    logic [31:0] wd3_w;
    logic        stall_e, flush_e;
    logic        valid_e;
    logic [3:0]  ra1_e, ra2_e, wa3_e;
    logic [31:0] rd1_e, rd2_e, imm_e;
    logic [7:0]  ctrl_e;
    logic        hazard_o;
`ifdef DEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_o;
`endif

    int nChecks = 0;
    int nFails  = 0;

    decode_execute_reg #(.CTRL_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .we3_w(we3_w), .wa3_w(wa3_w), .wd3_w(wd3_w),
        .stall_e(stall_e), .flush_e(flush_e),
        .valid_e(valid_e), .ra1_e(ra1_e), .ra2_e(ra2_e), .wa3_e(wa3_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .ctrl_e(ctrl_e),
        .hazard_o(hazard_o)
`ifdef DEX_PERF_CNT_EN
        , .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample shortly after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] w, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] im, input logic [7:0] c);
        valid_d = v; ra1_d = a1; ra2_d = a2; wa3_d = w;
        rd1_d = d1; rd2_d = d2; imm_d = im; ctrl_d = c;
    endtask

    task automatic writeback(input logic we, input logic [3:0] wa, input logic [31:0] wd);
        we3_w = we; wa3_w = wa; wd3_w = wd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
        drive(1'b1, 4'd3, 4'd7, 4'd9, 32'h55, 32'h66, 32'h77, 8'hFF);
        writeback(1'b0, 4'd0, 32'h0);
        step(); step();
        nChecks++; if (valid_e !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %0h expected 0", valid_e); end
        nChecks++; if (ctrl_e !== 8'h00) begin nFails++; $display("[TB] FAIL reset_ctrl: got %0h expected 0", ctrl_e); end
        nChecks++; if ({ra1_e, ra2_e, wa3_e} !== 12'h0) begin nFails++; $display("[TB] FAIL reset_addr: got %0h expected 0", {ra1_e, ra2_e, wa3_e}); end
        nChecks++; if ({rd1_e, rd2_e, imm_e} !== 96'h0) begin nFails++; $display("[TB] FAIL reset_data: got %0h expected 0", {rd1_e, rd2_e, imm_e}); end
        rst_n = 1'b1;
        drive(1'b1, 4'd3, 4'd7, 4'd9, 32'h11, 32'h66, 32'h77, 8'h00);
        step();
        nChecks++; if (rd1_e !== 32'h11) begin nFails++; $display("[TB] FAIL reset_release_rd1: got %0h expected 11", rd1_e); end
        nChecks++; if (valid_e !== 1'b1) begin nFails++; $display("[TB] FAIL reset_release_valid: got %0h expected 1", valid_e); end
        nChecks++; if (ra1_e !== 4'd3 || imm_e !== 32'h77) begin nFails++; $display("[TB] FAIL reset_release_fields: got ra1 %0h imm %0h expected 3 77", ra1_e, imm_e); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 4'd5, 4'd6, 4'd1, 32'hAAAA, 32'h5555, 32'h0, 8'h01);
        writeback(1'b1, 4'd5, 32'h1234);
        step();
        nChecks++; if (rd1_e !== 32'h1234) begin nFails++; $display("[TB] FAIL bypass_rd1: got %0h expected 1234", rd1_e); end
        nChecks++; if (rd2_e !== 32'h5555) begin nFails++; $display("[TB] FAIL bypass_rd2_nomatch: got %0h expected 5555", rd2_e); end
        drive(1'b1, 4'd15, 4'd6, 4'd1, 32'hAAAA, 32'h5555, 32'h0, 8'h01);
        writeback(1'b1, 4'd15, 32'h1234);
        step();
        nChecks++; if (rd1_e !== 32'hAAAA) begin nFails++; $display("[TB] FAIL bypass_r15: got %0h expected aaaa", rd1_e); end
        drive(1'b1, 4'd1, 4'd7, 4'd1, 32'hAAAA, 32'h5555, 32'h0, 8'h01);
        writeback(1'b1, 4'd7, 32'h77);
        step();
        nChecks++; if (rd2_e !== 32'h77 || rd1_e !== 32'hAAAA) begin nFails++; $display("[TB] FAIL bypass_rd2: got %0h/%0h expected 77/aaaa", rd2_e, rd1_e); end
        writeback(1'b0, 4'd0, 32'h0);
    endtask

    task automatic test_load_use();
        drive(1'b1, 4'd0, 4'd0, 4'd2, 32'h0, 32'h0, 32'h0, 8'h03);
        step();
        drive(1'b1, 4'd1, 4'd2, 4'd4, 32'h10, 32'h22, 32'h5, 8'h01);
        #1;
        nChecks++; if (hazard_o !== 1'b1) begin nFails++; $display("[TB] FAIL loaduse_hazard: got %0h expected 1", hazard_o); end
        step();
        nChecks++; if (valid_e !== 1'b0 || ctrl_e !== 8'h00) begin nFails++; $display("[TB] FAIL loaduse_bubble: got valid %0h ctrl %0h expected 0 0", valid_e, ctrl_e); end
        nChecks++; if (hazard_o !== 1'b0) begin nFails++; $display("[TB] FAIL loaduse_drop: got %0h expected 0", hazard_o); end
        step();
        nChecks++; if (valid_e !== 1'b1 || ctrl_e !== 8'h01 || wa3_e !== 4'd4 || rd2_e !== 32'h22) begin nFails++;
            $display("[TB] FAIL loaduse_reissue: got valid %0h ctrl %0h wa3 %0h rd2 %0h expected 1 01 4 22", valid_e, ctrl_e, wa3_e, rd2_e); end
        drive(1'b1, 4'd0, 4'd0, 4'd15, 32'h0, 32'h0, 32'h0, 8'h03);
        step();
        drive(1'b1, 4'd15, 4'd15, 4'd4, 32'h0, 32'h0, 32'h0, 8'h01);
        #1;
        nChecks++; if (hazard_o !== 1'b0) begin nFails++; $display("[TB] FAIL loaduse_r15: got %0h expected 0", hazard_o); end
        drive(1'b1, 4'd0, 4'd0, 4'd2, 32'h0, 32'h0, 32'h0, 8'h03);
        step();
        drive(1'b0, 4'd2, 4'd2, 4'd4, 32'h0, 32'h0, 32'h0, 8'hFF);
        #1;
        nChecks++; if (hazard_o !== 1'b0) begin nFails++; $display("[TB] FAIL loaduse_invalid_decode: got %0h expected 0", hazard_o); end
        step();
        nChecks++; if (valid_e !== 1'b0 || ctrl_e !== 8'h00) begin nFails++; $display("[TB] FAIL invalid_ctrl: got valid %0h ctrl %0h expected 0 0", valid_e, ctrl_e); end
    endtask

    task automatic test_stall_refresh();
        drive(1'b1, 4'd4, 4'd9, 4'd6, 32'h0, 32'h99, 32'h1234_5678, 8'h01);
        step();
        stall_e = 1'b1;
        drive(1'b1, 4'd1, 4'd1, 4'd1, 32'hFFFF, 32'hFFFF, 32'h0, 8'hFF);
        writeback(1'b1, 4'd4, 32'hBEEF);
        step();
        nChecks++; if (rd1_e !== 32'hBEEF) begin nFails++; $display("[TB] FAIL stall_refresh_rd1: got %0h expected beef", rd1_e); end
        nChecks++; if (rd2_e !== 32'h99 || imm_e !== 32'h1234_5678 || ctrl_e !== 8'h01) begin nFails++;
            $display("[TB] FAIL stall_hold_data: got rd2 %0h imm %0h ctrl %0h expected 99 12345678 01", rd2_e, imm_e, ctrl_e); end
        nChecks++; if (valid_e !== 1'b1 || ra1_e !== 4'd4 || ra2_e !== 4'd9 || wa3_e !== 4'd6) begin nFails++;
            $display("[TB] FAIL stall_hold_addr: got v %0h ra1 %0h ra2 %0h wa3 %0h expected 1 4 9 6", valid_e, ra1_e, ra2_e, wa3_e); end
        writeback(1'b1, 4'd9, 32'hCAFE);
        step();
        nChecks++; if (rd2_e !== 32'hCAFE || rd1_e !== 32'hBEEF) begin nFails++; $display("[TB] FAIL stall_refresh_rd2: got %0h/%0h expected cafe/beef", rd2_e, rd1_e); end
        writeback(1'b0, 4'd0, 32'h0);
        stall_e = 1'b0;
    endtask

    task automatic test_priority();
        stall_e = 1'b1; flush_e = 1'b1;
        step();
        nChecks++; if (valid_e !== 1'b0 || ctrl_e !== 8'h00 || rd2_e !== 32'h0) begin nFails++;
            $display("[TB] FAIL flush_over_stall: got valid %0h ctrl %0h rd2 %0h expected 0 0 0", valid_e, ctrl_e, rd2_e); end
        stall_e = 1'b0; flush_e = 1'b0;
        drive(1'b1, 4'd0, 4'd0, 4'd2, 32'h10, 32'h0, 32'h0, 8'h03);
        step();
        stall_e = 1'b1;
        drive(1'b1, 4'd2, 4'd0, 4'd5, 32'h0, 32'h0, 32'h0, 8'h01);
        step();
        nChecks++; if (valid_e !== 1'b1 || ctrl_e !== 8'h03 || wa3_e !== 4'd2 || rd1_e !== 32'h10) begin nFails++;
            $display("[TB] FAIL stall_over_hazard: got valid %0h ctrl %0h wa3 %0h rd1 %0h expected 1 03 2 10", valid_e, ctrl_e, wa3_e, rd1_e); end
        nChecks++; if (hazard_o !== 1'b1) begin nFails++; $display("[TB] FAIL stall_hazard_held: got %0h expected 1", hazard_o); end
        rst_n = 1'b0;
        step();
        nChecks++; if (valid_e !== 1'b0 || rd1_e !== 32'h0 || wa3_e !== 4'd0) begin nFails++;
            $display("[TB] FAIL reset_mid_stall: got valid %0h rd1 %0h wa3 %0h expected 0 0 0", valid_e, rd1_e, wa3_e); end
        rst_n = 1'b1; stall_e = 1'b0;
    endtask

`ifdef DEX_PERF_CNT_EN
    task automatic test_bubble_count();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        nChecks++; if (bubble_cnt_o !== 32'd0) begin nFails++; $display("[TB] FAIL count_reset: got %0d expected 0", bubble_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 4'd0, 4'd2, 32'h0, 32'h0, 32'h0, 8'h03);
            step();
            drive(1'b1, 4'd2, 4'd0, 4'd5, 32'h0, 32'h0, 32'h0, 8'h01);
            step();
        end
        flush_e = 1'b1;
        step();
        flush_e = 1'b0;
        nChecks++; if (bubble_cnt_o !== 32'd3) begin nFails++; $display("[TB] FAIL count_three: got %0d expected 3", bubble_cnt_o); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        nChecks++; if (bubble_cnt_o !== 32'd0) begin nFails++; $display("[TB] FAIL count_cleared: got %0d expected 0", bubble_cnt_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_stall_refresh();
        test_priority();
`ifdef DEX_PERF_CNT_EN
        test_bubble_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
